// File: rtl/logic_op_scheduler_pkg.sv
// Shared types for the logic-op scheduler.
// Op encodings, FSM states and id-width helper.
package logic_op_pkg;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_OR  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_EXEC,
    S_RESP
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_op_scheduler_if.sv
// Request/result bus of the logic-op scheduler.
// Clients drive requests, the scheduler returns tagged results.
interface logic_op_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       op;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_data;
  logic                  busy;

  modport master (
    output req, op, a_in, b_in, res_ready,
    input  gnt, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req, op, a_in, b_in, res_ready,
    output gnt, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/logic_op_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW:0] slot;

  // scan from the farthest offset down so the nearest hit wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    slot   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + (IDW + 1)'(k);
      if (slot >= (IDW + 1)'(NREQ))
        slot = slot - (IDW + 1)'(NREQ);
      if (req[slot[IDW-1:0]]) begin
        idx = slot[IDW-1:0];
        any = 1'b1;
      end
    end
    if (any)
      onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler for one shared AND/OR unit.
// Grants a requester, computes its op, returns a tagged result.
module logic_op_scheduler
  import logic_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = id_width(NREQ)
) (
  input logic                 clk,
  input logic                 rst,
  logic_op_scheduler_if.slave bus
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [NREQ-1:0]  gnt_q;
  logic             valid_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  logic             unit_sel;
  logic [WIDTH-1:0] unit_out;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .onehot(win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign unit_sel = op_q;
  assign unit_out = (unit_sel == OP_OR) ? (a_q | b_q)
                                        : (a_q & b_q);

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = valid_q;
  assign bus.res_id    = id_q;
  assign bus.res_data  = data_q;
  assign bus.busy      = busy_q;

  // grant, latch operands, execute, hold result until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_any) begin
            op_q   <= bus.op[win_idx];
            a_q    <= bus.a_in[win_idx*WIDTH +: WIDTH];
            b_q    <= bus.b_in[win_idx*WIDTH +: WIDTH];
            id_q   <= win_idx;
            gnt_q  <= win_oh;
            busy_q <= 1'b1;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          gnt_q  <= '0;
          rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0
                                             : id_q + 1'b1;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          data_q  <= unit_out;
          valid_q <= 1'b1;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler.
// Cycle model plus result scoreboard.
module tb_logic_op_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic_op_scheduler_if #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) bus ();

  logic_op_scheduler #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } res_t;

  int               checks = 0;
  int               errors = 0;
  res_t             sb[$];
  int               glog[$];
  int               m_ph   = 0;
  int               m_ptr  = 0;
  logic             prev_v = 1'b0;
  logic [IDW-1:0]   last_id = '0;
  logic [WIDTH-1:0] last_data = '0;
  logic [WIDTH-1:0] obs[NREQ];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r,
                              input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] eg;
    res_t e;
    int w;
    @(posedge clk);
    eg = '0;
    case (m_ph)
      0: if (|bus.req) begin
        w = pick(bus.req, m_ptr);
        e.id = IDW'(w);
        e.data = bus.op[w]
          ? (bus.a_in[w*WIDTH +: WIDTH] | bus.b_in[w*WIDTH +: WIDTH])
          : (bus.a_in[w*WIDTH +: WIDTH] & bus.b_in[w*WIDTH +: WIDTH]);
        sb.push_back(e);
        eg[w] = 1'b1;
        m_ptr = (w + 1) % NREQ;
        m_ph = 1;
      end
      1: m_ph = 2;
      2: m_ph = 3;
      default: if (bus.res_ready) m_ph = 0;
    endcase
    #1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("valid", 32'(bus.res_valid), 32'(m_ph == 3));
    chk("busy", 32'(bus.busy), 32'(m_ph != 0));
    if (bus.gnt != '0) glog.push_back(pick(bus.gnt, 0));
    if (bus.res_valid && !prev_v) begin
      chk("sb_pop", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_id", 32'(bus.res_id), 32'(e.id));
        chk("res_data", 32'(bus.res_data), 32'(e.data));
      end
      last_id = bus.res_id;
      last_data = bus.res_data;
      obs[bus.res_id] = bus.res_data;
    end else if (bus.res_valid) begin
      chk("hold_id", 32'(bus.res_id), 32'(last_id));
      chk("hold_data", 32'(bus.res_data), 32'(last_data));
    end
    prev_v = bus.res_valid;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_id"}, 32'(bus.res_id), 0);
    chk({tag, "_data"}, 32'(bus.res_data), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_ptr = 0;
    sb.delete();
    prev_v = 1'b0;
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (bus.gnt != '0) return;
    end
    chk({tag, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (bus.res_valid) return;
    end
    chk({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic drain();
    bus.req = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!bus.busy) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bus.req = '0;
    bus.op = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.res_ready = 1'b0;

    // T1: reset, idle
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) cycle();

    // T2: single AND on slot 0
    bus.op = 4'b0000;
    bus.a_in[7:0] = 8'hF0;
    bus.b_in[7:0] = 8'h3C;
    bus.res_ready = 1'b1;
    bus.req = 4'b0001;
    wait_gnt("t2");
    chk("t2_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    cycle();
    chk("t2_gnt_off", 32'(bus.gnt), 0);
    cycle();
    chk("t2_lat", 32'(bus.res_valid), 1);
    chk("t2_data", 32'(bus.res_data), 32'h30);
    chk("t2_id", 32'(bus.res_id), 0);
    drain();

    // T3: all requesting, OR ops, rr order
    rst = 1'b1;
    #1;
    chk_zero("t3rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.op = 4'b1111;
    bus.a_in = {8'h33, 8'h0F, 8'h55, 8'hC0};
    bus.b_in = {8'h44, 8'hA0, 8'h0A, 8'h03};
    bus.res_ready = 1'b1;
    bus.req = 4'b1111;
    glog.delete();
    for (int i = 0; i < 40 && glog.size() < 5; i++) cycle();
    bus.req = '0;
    chk("t3_ngnt", 32'(glog.size()), 5);
    if (glog.size() == 5) begin
      chk("t3_g0", 32'(glog[0]), 0);
      chk("t3_g1", 32'(glog[1]), 1);
      chk("t3_g2", 32'(glog[2]), 2);
      chk("t3_g3", 32'(glog[3]), 3);
      chk("t3_g4", 32'(glog[4]), 0);
    end
    drain();
    chk("t3_slot2", 32'(obs[2]), 32'hAF);

    // T4: backpressure, ptr at 1
    bus.res_ready = 1'b0;
    bus.req = 4'b1000;
    wait_gnt("t4a");
    chk("t4_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b1010;
    wait_valid("t4");
    chk("t4_id", 32'(bus.res_id), 3);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_nognt", 32'(bus.gnt), 0);
      chk("t4_hold", 32'(bus.res_valid), 1);
    end
    bus.res_ready = 1'b1;
    wait_gnt("t4b");
    chk("t4_gnt1", 32'(bus.gnt), 32'h2);
    drain();

    // T5: reset during EXEC
    bus.req = 4'b0001;
    bus.res_ready = 1'b1;
    wait_gnt("t5a");
    bus.req = '0;
    cycle();
    rst = 1'b1;
    #1;
    chk_zero("t5rst");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("t5_nov", 32'(bus.res_valid), 0);
    end
    rst = 1'b0;
    bus.req = 4'b0100;
    wait_gnt("t5b");
    chk("t5_gnt", 32'(bus.gnt), 32'h4);
    drain();

    // T6: random traffic
    for (int i = 0; i < 10000; i++) begin
      bus.req = NREQ'($urandom);
      bus.op = NREQ'($urandom);
      bus.a_in = (NREQ*WIDTH)'($urandom);
      bus.b_in = (NREQ*WIDTH)'($urandom);
      bus.res_ready = 1'($urandom);
      cycle();
    end
    drain();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
